// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit
//   Registered decode/control stage of the 3-stage RISC-V core. The full
//   32-bit instruction is decoded combinationally and captured into the EX
//   pipeline register that drives the EX-stage control lines. Multi-cycle
//   M-extension ops hold the EX register and stall fetch through a small
//   countdown state machine. Bubbles and flushes load the reset value.
//
// Ports
//   clk, rst_n       core clock, synchronous active-low reset
//   instr_i          instruction from fetch
//   instr_valid_i    instr_i is real (0 = bubble)
//   flush_i          kill EX instruction and any multi-cycle sequence
//   stall_o          fetch must hold PC/instr_i next cycle
//   alusrc_EX        00 rs1/rs2, 01 rs1/I-imm, 10 zero/U-imm
//   regsel_EX        00 ALU, 01 GPIO input (CSR read), 10 U-imm
//   aluop_EX         ALU operation code
//   md_unsigned_EX   DIVU/REMU select
//   regwrite_EX      write rd this cycle
//   gpio_we_EX       write GPIO output register this cycle
//   rd_EX            destination register
//   illegal_EX       unsupported encoding in EX
//   mdu_busy_o       multi-cycle op in progress
module ctrl_pipe_unit #(
    parameter int unsigned MUL_CYCLES = 1,
    parameter int unsigned DIV_CYCLES = 32,
    parameter bit          ENABLE_M   = 1'b1,
    parameter logic [11:0] GPIO_CSR   = 12'hF02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [1:0]  alusrc_EX,
    output logic [1:0]  regsel_EX,
    output logic [3:0]  aluop_EX,
    output logic        md_unsigned_EX,
    output logic        regwrite_EX,
    output logic        gpio_we_EX,
    output logic [4:0]  rd_EX,
    output logic        illegal_EX,
    output logic        mdu_busy_o
);

    // ALU operation codes
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_XOR    = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_MUL    = 4'b1010;
    localparam logic [3:0] ALU_MULH   = 4'b1011;
    localparam logic [3:0] ALU_MULHSU = 4'b1100;
    localparam logic [3:0] ALU_MULHU  = 4'b1101;
    localparam logic [3:0] ALU_DIV    = 4'b1110;
    localparam logic [3:0] ALU_REM    = 4'b1111;

    // Major opcodes handled here
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    // Countdown sized for the longer of the two multi-cycle ops
    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int          CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam bit              MUL_MULTI = (MUL_CYCLES > 1);
    localparam bit              DIV_MULTI = (DIV_CYCLES > 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef struct packed {
        logic [1:0] alusrc;
        logic [1:0] regsel;
        logic [3:0] aluop;
        logic       md_unsigned;
        logic       regwrite;
        logic       gpio_we;
        logic [4:0] rd;
        logic       illegal;
    } ex_ctl_t;

    localparam ex_ctl_t EX_RESET = '{
        alusrc:      2'b00,
        regsel:      2'b00,
        aluop:       ALU_ADD,
        md_unsigned: 1'b0,
        regwrite:    1'b0,
        gpio_we:     1'b0,
        rd:          5'd0,
        illegal:     1'b0
    };

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    ex_ctl_t          ex, ex_nx;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr;
    logic [4:0]  rd;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign csr    = instr_i[31:20];

    // rs1 is consumed by the register file, not by control
    logic unused_rs1;
    assign unused_rs1 = ^instr_i[19:15];

    // funct3 to base ALU op (shared by R-type funct7=0 and I-type)
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] m_op(input logic [2:0] f3);
        case (f3)
            3'b000:         m_op = ALU_MUL;
            3'b001:         m_op = ALU_MULH;
            3'b010:         m_op = ALU_MULHSU;
            3'b011:         m_op = ALU_MULHU;
            3'b100, 3'b101: m_op = ALU_DIV;
            default:        m_op = ALU_REM;
        endcase
    endfunction

    ex_ctl_t dec, raw;
    logic    legal;
    logic    is_mop;
    logic    is_div;

    always_comb begin
        raw    = EX_RESET;
        legal  = 1'b0;
        is_mop = 1'b0;
        is_div = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct7)
                    7'h00: begin
                        legal     = 1'b1;
                        raw.aluop = base_op(funct3);
                    end
                    7'h20: begin
                        if (funct3 == 3'b000) begin
                            legal     = 1'b1;
                            raw.aluop = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            legal     = 1'b1;
                            raw.aluop = ALU_SRA;
                        end
                    end
                    7'h01: begin
                        if (ENABLE_M) begin
                            legal           = 1'b1;
                            is_mop          = 1'b1;
                            is_div          = funct3[2];
                            raw.aluop       = m_op(funct3);
                            raw.md_unsigned = funct3[2] & funct3[0];
                        end
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                raw.alusrc = 2'b01;
                raw.aluop  = base_op(funct3);
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'h00);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'h00) begin
                        legal = 1'b1;
                    end else if (funct7 == 7'h20) begin
                        legal     = 1'b1;
                        raw.aluop = ALU_SRA;
                    end
                end else begin
                    legal = 1'b1;
                end
            end
            OP_LUI: begin
                legal      = 1'b1;
                raw.alusrc = 2'b10;
                raw.regsel = 2'b10;
            end
            OP_SYS: begin
                // Only CSRRW to the GPIO CSR is implemented
                if (funct3 == 3'b001 && csr == GPIO_CSR) begin
                    legal       = 1'b1;
                    raw.regsel  = 2'b01;
                    raw.gpio_we = 1'b1;
                end
            end
            default: ;
        endcase

        if (legal) begin
            dec          = raw;
            dec.rd       = rd;
            dec.regwrite = (rd != 5'd0);
        end else begin
            dec         = EX_RESET;
            dec.illegal = 1'b1;
        end
    end

    // Legal M op whose latency exceeds one EX cycle
    logic             multi;
    logic [CNT_W-1:0] load_cnt;

    assign multi    = is_mop & (is_div ? DIV_MULTI : MUL_MULTI);
    assign load_cnt = is_div ? DIV_LOAD : MUL_LOAD;

    // ------------------------------------------------------------------
    // EX register and multi-cycle sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            ex    <= EX_RESET;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ex    <= ex_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ex_nx    = ex;
        if (flush_i) begin
            // Flush beats both a new instruction and M-op completion
            state_nx = RUN;
            cnt_nx   = '0;
            ex_nx    = EX_RESET;
        end else begin
            case (state)
                RUN: begin
                    if (instr_valid_i) begin
                        ex_nx = dec;
                        if (multi) begin
                            state_nx = MDU_WAIT;
                            cnt_nx   = load_cnt;
                        end
                    end else begin
                        ex_nx = EX_RESET;
                    end
                end
                MDU_WAIT: begin
                    // EX register holds; fetch is stalled so instr_i is ignored.
                    // Leaving at cnt==1 makes the following cycle the final
                    // EX cycle, seen in RUN with stall low.
                    cnt_nx = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nx = RUN;
                    end
                end
                default: begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic waiting;
    assign waiting = (state == MDU_WAIT);

    assign stall_o        = waiting;
    assign mdu_busy_o     = waiting;
    assign alusrc_EX      = ex.alusrc;
    assign regsel_EX      = ex.regsel;
    assign aluop_EX       = ex.aluop;
    assign md_unsigned_EX = ex.md_unsigned;
    // M-op writeback only in its final EX cycle
    assign regwrite_EX    = ex.regwrite & ~waiting;
    assign gpio_we_EX     = ex.gpio_we;
    assign rd_EX          = ex.rd;
    assign illegal_EX     = ex.illegal;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
module tb_ctrl_pipe_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        valid;
    logic        flush;

    logic       stall  [2];
    logic [1:0] alusrc [2];
    logic [1:0] regsel [2];
    logic [3:0] aluop  [2];
    logic       mdu    [2];
    logic       rw     [2];
    logic       gwe    [2];
    logic [4:0] rd     [2];
    logic       ill    [2];
    logic       busy   [2];

    // dut 0: M enabled, single-cycle MUL, 4-cycle DIV
    ctrl_pipe_unit #(.MUL_CYCLES(1), .DIV_CYCLES(4), .ENABLE_M(1'b1), .GPIO_CSR(12'hF02)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid), .flush_i(flush),
        .stall_o(stall[0]), .alusrc_EX(alusrc[0]), .regsel_EX(regsel[0]), .aluop_EX(aluop[0]),
        .md_unsigned_EX(mdu[0]), .regwrite_EX(rw[0]), .gpio_we_EX(gwe[0]), .rd_EX(rd[0]),
        .illegal_EX(ill[0]), .mdu_busy_o(busy[0])
    );

    // dut 1: M disabled
    ctrl_pipe_unit #(.MUL_CYCLES(3), .DIV_CYCLES(5), .ENABLE_M(1'b0), .GPIO_CSR(12'hF02)) dut_nom (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(valid), .flush_i(flush),
        .stall_o(stall[1]), .alusrc_EX(alusrc[1]), .regsel_EX(regsel[1]), .aluop_EX(aluop[1]),
        .md_unsigned_EX(mdu[1]), .regwrite_EX(rw[1]), .gpio_we_EX(gwe[1]), .rd_EX(rd[1]),
        .illegal_EX(ill[1]), .mdu_busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] alusrc;
        logic [1:0] regsel;
        logic [3:0] aluop;
        logic       mdu;
        logic       rw;
        logic       gwe;
        logic [4:0] rd;
        logic       ill;
        logic [7:0] ncyc;   // EX cycles the instruction occupies
    } exp_t;

    localparam exp_t BUB = '{alusrc: 2'd0, regsel: 2'd0, aluop: 4'd3, mdu: 1'b0, rw: 1'b0,
                             gwe: 1'b0, rd: 5'd0, ill: 1'b0, ncyc: 8'd1};

    bit en_m [2] = '{1'b1, 1'b0};
    int mulc [2] = '{1, 3};
    int divc [2] = '{4, 5};

    exp_t m   [2];
    int   rem [2];   // EX cycles still to go after the current one

    function automatic exp_t ref_decode(logic [31:0] ins, bit em, int mc, int dc);
        exp_t       e = BUB;
        logic [3:0] btab [8];
        logic [3:0] mtab [8];
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        bit         ok = 0;
        btab = '{4'd3, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd1, 4'd0};
        mtab = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15, 4'd15};
        if (op == 7'h33) begin
            if (f7 == 7'h00) begin
                ok = 1; e.aluop = btab[f3];
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                ok = 1; e.aluop = (f3 == 3'd0) ? 4'd4 : 4'd7;
            end else if (f7 == 7'h01 && em) begin
                ok = 1; e.aluop = mtab[f3];
                e.mdu  = (f3 == 3'd5 || f3 == 3'd7);
                e.ncyc = 8'((f3 >= 3'd4) ? dc : mc);
            end
        end else if (op == 7'h13) begin
            e.alusrc = 2'd1;
            e.aluop  = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : btab[f3];
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
            else                 ok = 1;
        end else if (op == 7'h37) begin
            ok = 1; e.alusrc = 2'd2; e.regsel = 2'd2;
        end else if (op == 7'h73 && f3 == 3'd1 && ins[31:20] == 12'hF02) begin
            ok = 1; e.regsel = 2'd1; e.gwe = 1;
        end
        if (!ok) begin
            e = BUB; e.ill = 1;
        end else begin
            e.rd = ins[11:7];
            e.rw = (ins[11:7] != 5'd0);
        end
        return e;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || flush) begin
                m[i] = BUB; rem[i] = 0;
            end else if (rem[i] > 0) begin
                rem[i]--;
            end else if (valid) begin
                m[i]   = ref_decode(instr, en_m[i], mulc[i], divc[i]);
                rem[i] = int'(m[i].ncyc) - 1;
            end else begin
                m[i] = BUB;
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_stall", i),  stall[i],  rem[i] > 0);
            chk($sformatf("d%0d_busy", i),   busy[i],   rem[i] > 0);
            chk($sformatf("d%0d_alusrc", i), alusrc[i], m[i].alusrc);
            chk($sformatf("d%0d_regsel", i), regsel[i], m[i].regsel);
            chk($sformatf("d%0d_aluop", i),  aluop[i],  m[i].aluop);
            chk($sformatf("d%0d_mdu", i),    mdu[i],    m[i].mdu);
            chk($sformatf("d%0d_rw", i),     rw[i],     m[i].rw && rem[i] == 0);
            chk($sformatf("d%0d_gwe", i),    gwe[i],    m[i].gwe);
            chk($sformatf("d%0d_rd", i),     rd[i],     m[i].rd);
            chk($sformatf("d%0d_ill", i),    ill[i],    m[i].ill);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic issue(input logic [31:0] ins, input logic v, input logic f);
        instr = ins; valid = v; flush = f;
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  f7;
        logic [6:0]  ops [4];
        ops = '{7'h33, 7'h13, 7'h37, 7'h73};
        case ($urandom_range(0, 5))
            0, 1: begin
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    2: f7 = 7'h01;
                    default: f7 = r[31:25];
                endcase
                r[31:25] = f7;
                r[6:0]   = ops[$urandom_range(0, 1)];
            end
            2: r[6:0] = 7'h37;
            3: begin
                r[6:0] = 7'h73;
                if ($urandom_range(0, 2) != 0) r[14:12] = 3'd1;
                case ($urandom_range(0, 2))
                    0: r[31:20] = 12'hF02;
                    1: r[31:20] = 12'hF00;
                    default: ;
                endcase
            end
            4: begin
                r[6:0] = 7'h33; r[31:25] = 7'h01;
            end
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    initial begin
        int cnt;
        rst_n = 1'b0; instr = 32'h0; valid = 1'b0; flush = 1'b0;
        tick();
        tick();
        // reset state
        chk("rst_aluop", aluop[0], 32'h3);
        chk("rst_rw", rw[0], 0);
        chk("rst_stall", stall[0], 0);
        rst_n = 1'b1;

        // addi x1,x0,5
        issue(32'h00500093, 1, 0);
        chk("addi_alusrc", alusrc[0], 1);
        chk("addi_aluop", aluop[0], 3);
        chk("addi_rw", rw[0], 1);
        chk("addi_rd", rd[0], 1);
        chk("addi_stall", stall[0], 0);

        // sub then sra
        issue(32'h402081B3, 1, 0);
        chk("sub_aluop", aluop[0], 4);
        issue(32'h4020D1B3, 1, 0);
        chk("sra_aluop", aluop[0], 7);

        // div x5,x6,x7 with 4 EX cycles; addi waits on instr_i
        issue(32'h027342B3, 1, 0);
        instr = 32'h00500093;
        cnt = 0;
        while (stall[0] && cnt < 10) begin
            chk("div_rw_early", rw[0], 0);
            cnt++;
            tick();
        end
        chk("div_stall_cycles", cnt, 3);
        chk("div_rw_final", rw[0], 1);
        chk("div_rd", rd[0], 5);
        chk("div_aluop", aluop[0], 14);
        tick();
        chk("after_div_accept", aluop[0], 3);
        chk("after_div_rd", rd[0], 1);

        // flush in 2nd cycle of div
        issue(32'h027342B3, 1, 0);
        issue(32'h027342B3, 1, 0);
        chk("flush_pre_busy", busy[0], 1);
        issue(32'h00500093, 1, 1);
        chk("flush_stall", stall[0], 0);
        chk("flush_busy", busy[0], 0);
        chk("flush_rw", rw[0], 0);
        chk("flush_aluop", aluop[0], 3);
        issue(32'h0, 0, 0);
        chk("flush_no_rw", rw[0], 0);

        // CSR writes
        issue(32'hF0229073, 1, 0);
        chk("csr_gwe", gwe[0], 1);
        chk("csr_rw_x0", rw[0], 0);
        chk("csr_regsel", regsel[0], 1);
        issue(32'hF0029073, 1, 0);
        chk("csr_f00_gwe", gwe[0], 0);
        chk("csr_f00_ill", ill[0], 1);

        // mul: single-cycle with M, illegal without
        issue(32'h022081B3, 1, 0);
        chk("mul_aluop", aluop[0], 10);
        chk("mul_rw", rw[0], 1);
        chk("mul_stall", stall[0], 0);
        chk("nom_mul_ill", ill[1], 1);
        chk("nom_mul_rw", rw[1], 0);
        chk("nom_mul_stall", stall[1], 0);
        issue(32'hFFFFFFFF, 1, 0);
        chk("ones_ill", ill[0], 1);
        chk("ones_ill_nom", ill[1], 1);

        // divu, then reset in MDU_WAIT
        issue(32'h027352B3, 1, 0);
        chk("divu_mdu", mdu[0], 1);
        rst_n = 1'b0;
        issue(32'h0, 0, 0);
        chk("rst_wait_rw", rw[0], 0);
        chk("rst_wait_stall", stall[0], 0);
        rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            issue(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Registered decode/control stage for the 3-stage RISC-V core. Decodes the full 32-bit instruction (opcode, funct3, funct7, CSR field) and drives the EX-stage control lines from a pipeline register. Sequences multi-cycle M-extension operations with a countdown state machine that stalls fetch. Handles bubbles and flushes. Replaces the purely combinational type-based control decode.

## Interface
- MUL_CYCLES, 1: EX cycles occupied by MUL/MULH/MULHSU/MULHU (≥1).
- DIV_CYCLES, 32: EX cycles occupied by DIV/DIVU/REM/REMU (≥1).
- ENABLE_M, 1: 0 makes every funct7=0x01 R-type decode as illegal.
- GPIO_CSR, 12'hF02: CSR address whose CSRRW write drives gpio_we_EX.

- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- instr_i  in  32  instruction from fetch
- instr_valid_i  in  1  instr_i is a real instruction (0 = bubble)
- flush_i  in  1  kill instruction in EX and any multi-cycle sequence
- stall_o  out  1  fetch must hold PC/instr_i next cycle
- alusrc_EX  out  2  00 rs1/rs2, 01 rs1/I-imm, 10 zero/U-imm
- regsel_EX  out  2  00 ALU, 01 GPIO input (CSR read), 10 U-imm
- aluop_EX  out  4  ALU operation code
- md_unsigned_EX  out  1  DIVU/REMU select
- regwrite_EX  out  1  write rd this cycle
- gpio_we_EX  out  1  write GPIO output register this cycle
- rd_EX  out  5  destination register
- illegal_EX  out  1  unsupported encoding in EX
- mdu_busy_o  out  1  multi-cycle op in progress

## Operation
- aluop: AND 0000, OR 0001, XOR 0010, ADD 0011, SUB 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, MUL 1010, MULH 1011, MULHSU 1100, MULHU 1101, DIV/DIVU 1110, REM/REMU 1111.
- R-type (0110011): funct7 0x00 → base ops. funct7 0x20 → SUB/SRA only. funct7 0x01 → M ops. alusrc 00, regsel 00.
- I-type ALU (0010011): alusrc 01. SLLI/SRLI need funct7 0x00, SRAI needs funct7 0x20; otherwise illegal.
- LUI (0110111): regsel 10, alusrc 10, aluop ADD.
- CSRRW (1110011, funct3 001), csr==GPIO_CSR: gpio_we_EX=1, regwrite_EX=1, regsel 01.
- Any other encoding sets illegal_EX=1 with all write enables 0. rd_x0 suppresses regwrite_EX but not gpio_we_EX.
- Bubble: instr_valid_i=0 or flush_i=1 loads the EX register with reset values.
- FSM states:
  - RUN → MDU_WAIT when an M op with N=MUL_CYCLES or DIV_CYCLES >1 loads; counter=N-1.
  - MDU_WAIT decrements each cycle and → RUN after the cycle where counter reaches 1.
  - In MDU_WAIT, the EX register holds and instr_i is ignored.
- regwrite_EX for an M op asserts only in its final EX cycle.

## Timing
- Decode latency 1: instruction accepted at edge t drives EX outputs during cycle t+1.
- N=1 ops: single EX cycle, stall_o never asserted.
- N>1 ops: stall_o and mdu_busy_o are high for EX cycles 1..N-1 and low in cycle N. The next instruction is accepted at the end of cycle N.
- flush_i, at any state: the next edge produces a bubble, counter 0, state RUN, with stall_o low the following cycle. Flush wins over a simultaneous valid instruction or M-op completion.
- Reset (rst_n=0 at edge): state RUN, counter 0, and every output 0 except aluop_EX=0011.
- Reset during MDU_WAIT aborts with no regwrite_EX pulse.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) valid: next cycle alusrc 01, aluop 0011, regwrite 1, rd 1, stall_o 0.
- sub x3,x1,x2 (0x402081B3) followed by sra (0x4020D1B3): aluop 0100 then 0111, one cycle each.
- div x5,x6,x7 (0x027342B3) with DIV_CYCLES=4: stall_o high for 3 cycles, regwrite only in cycle 4, next instr_i accepted after cycle 4.
- flush_i in the 2nd cycle of that div: next cycle all enables 0, stall_o 0, mdu_busy_o 0, no regwrite pulse.
- csrrw x0,0xF02,x5 (0xF0229073): gpio_we_EX 1, regwrite_EX 0; csr 0xF00 gives gpio_we_EX 0.
- ENABLE_M=0 with mul (0x022081B3): illegal_EX 1, regwrite 0, no stall; also instr 0xFFFFFFFF gives illegal_EX 1.
